// File: rtl/leftvnorm.sv
// Sequential left-shift normalizer: shifts an operand left one bit per cycle
// until its MSB is set and reports how many shifts were applied.
module leftvnorm #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic [CW-1:0] shift,
  output logic          zero,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] work_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          zero_nxt;

  // out/shift/zero are the working registers themselves, so they hold after
  // DONE until the next accepted start overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      shift <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= work_nxt;
      shift <= cnt_nxt;
      zero  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = out;
    cnt_nxt   = shift;
    zero_nxt  = zero;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = in;
          cnt_nxt   = '0;
          zero_nxt  = 1'b0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (out == '0) begin
          zero_nxt  = 1'b1;
          cnt_nxt   = CW'(DW);
          state_nxt = DONE;
        end else if (out[DW-1]) begin
          state_nxt = DONE;
        end else begin
          work_nxt = {out[DW-2:0], 1'b0};
          cnt_nxt  = shift + CW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_leftvnorm.sv
// Directed bench for leftvnorm: reset, normalization cases, hold, ignored
// starts, back-to-back accept and mid-operation reset.
module tb_leftvnorm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic [4:0]  shift;
  logic        zero;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  leftvnorm #(.DW(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in),
    .out(out), .shift(shift), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle; returns 1 time unit after the accepting edge.
  task automatic do_start(input logic [15:0] d);
    start = 1'b1;
    in    = d;
    tick();
    start = 1'b0;
    in    = 16'($urandom_range(0, 65535));
  endtask

  // Count edges until done is seen and cycles with busy high (bounded).
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      tick();
      lat++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: done not seen within %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (out !== 16'h0) begin n_err++; $display("FAIL reset_out: got %h want 0000", out); end
    n_cmp++; if (shift !== 5'd0) begin n_err++; $display("FAIL reset_shift: got %0d want 0", shift); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_set();
    int lat, bc;
    do_start(16'h8000);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL msb_lat: got %0d want 1", lat); end
    n_cmp++; if (bc !== 1) begin n_err++; $display("FAIL msb_busy: got %0d want 1", bc); end
    n_cmp++; if (out !== 16'h8000) begin n_err++; $display("FAIL msb_out: got %h want 8000", out); end
    n_cmp++; if (shift !== 5'd0) begin n_err++; $display("FAIL msb_shift: got %0d want 0", shift); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL msb_zero: got %b want 0", zero); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL msb_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL msb_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int lat, bc;
    do_start(16'h0000);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zero_lat: got %0d want 1", lat); end
    n_cmp++; if (bc !== 1) begin n_err++; $display("FAIL zero_busy: got %0d want 1", bc); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", zero); end
    n_cmp++; if (shift !== 5'd16) begin n_err++; $display("FAIL zero_shift: got %0d want 16", shift); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL zero_out: got %h want 0000", out); end
    tick();
  endtask

  task automatic test_lsb();
    int lat, bc;
    do_start(16'h0001);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL lsb_lat: got %0d want 16", lat); end
    n_cmp++; if (bc !== 16) begin n_err++; $display("FAIL lsb_busy: got %0d want 16", bc); end
    n_cmp++; if (out !== 16'h8000) begin n_err++; $display("FAIL lsb_out: got %h want 8000", out); end
    n_cmp++; if (shift !== 5'd15) begin n_err++; $display("FAIL lsb_shift: got %0d want 15", shift); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL lsb_zero: got %b want 0", zero); end
    tick();
  endtask

  task automatic test_hold();
    int lat, bc;
    do_start(16'h00F3);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL hold_lat: got %0d want 9", lat); end
    n_cmp++; if (out !== 16'hF300) begin n_err++; $display("FAIL hold_out: got %h want F300", out); end
    n_cmp++; if (shift !== 5'd8) begin n_err++; $display("FAIL hold_shift: got %0d want 8", shift); end
    for (int i = 0; i < 5; i++) begin
      in = 16'($urandom_range(0, 65535));
      tick();
      n_cmp++; if (out !== 16'hF300) begin n_err++; $display("FAIL hold_out_idle%0d: got %h want F300", i, out); end
      n_cmp++; if (shift !== 5'd8) begin n_err++; $display("FAIL hold_shift_idle%0d: got %0d want 8", i, shift); end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL hold_ctl_idle%0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_start(16'h0004);
    start = 1'b1;
    in    = 16'hFFFF;
    repeat (3) tick();
    start = 1'b0;
    wait_done(lat, bc);
    lat = lat + 3;
    n_cmp++; if (lat !== 14) begin n_err++; $display("FAIL b2b_lat: got %0d want 14", lat); end
    n_cmp++; if (out !== 16'h8000) begin n_err++; $display("FAIL b2b_out: got %h want 8000", out); end
    n_cmp++; if (shift !== 5'd13) begin n_err++; $display("FAIL b2b_shift: got %0d want 13", shift); end
    tick();
    do_start(16'h0030);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL b2b2_lat: got %0d want 11", lat); end
    n_cmp++; if (out !== 16'hC000) begin n_err++; $display("FAIL b2b2_out: got %h want C000", out); end
    n_cmp++; if (shift !== 5'd10) begin n_err++; $display("FAIL b2b2_shift: got %0d want 10", shift); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    do_start(16'h0001);
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out !== 16'h0) begin n_err++; $display("FAIL rmid_out: got %h want 0000", out); end
    n_cmp++; if (shift !== 5'd0) begin n_err++; $display("FAIL rmid_shift: got %0d want 0", shift); end
    n_cmp++; if (zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctl: got zero=%b busy=%b done=%b want 0 0 0", zero, busy, done);
    end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got busy=%b want 0", busy); end
    do_start(16'h0100);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL rmid_lat: got %0d want 8", lat); end
    n_cmp++; if (out !== 16'h8000) begin n_err++; $display("FAIL rmid_res_out: got %h want 8000", out); end
    n_cmp++; if (shift !== 5'd7) begin n_err++; $display("FAIL rmid_res_shift: got %0d want 7", shift); end
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_set();
    test_zero();
    test_lsb();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
